// File: rtl/spram_ctrl.sv
// spram_ctrl: request/response front end for a single-port RAM with
// registered read data. Requests pass straight through to the RAM port.
// Read data is captured one cycle after issue into a 3-entry response FIFO.
// req_ready is a credit check on registered state: it is deasserted before
// the FIFO could overflow, so responses never need to be dropped.
module spram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 256,
    localparam int AW = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [AW-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_en,
    output logic                  ram_wr_en,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    logic                  pending;
    logic [1:0]            count;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [3];
    logic                  req_fire;
    logic                  push;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Handshake, credit check and combinational RAM-port pass-through.
    always_comb begin
        req_ready   = !rst && (({1'b0, count} + {2'b00, pending}) < 3'd3);
        req_fire    = req_valid && req_ready;
        ram_en      = req_fire;
        ram_wr_en   = req_fire && req_wr;
        ram_addr    = req_addr;
        ram_wr_data = req_wdata;
        rsp_valid   = (count != 2'd0);
        rsp_data    = fifo_mem[rd_ptr];
        push        = pending;
        pop         = rsp_valid && rsp_ready;
    end

    // Read-in-flight flag, FIFO occupancy and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            pending <= req_fire && !req_wr;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Response storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= ram_rd_data;
    end

endmodule

// File: tb/tb_spram_ctrl.sv
// Directed and constrained-random bench for spram_ctrl with a behavioural
// single-port RAM (registered read data) attached to the RAM port.
module tb_spram_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          ram_en;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_rd_data;

    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    spram_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .ram_en      (ram_en),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    // RAM model: preloaded with 0xA0+addr while in reset, registered read.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++)
                ram_mem[i] <= 8'(i + 160);
        end else if (ram_en) begin
            if (ram_wr_en)
                ram_mem[ram_addr] <= ram_wr_data;
            else
                ram_rd_data <= ram_mem[ram_addr];
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic       exp_ready [6];
        int         na;
        logic       prev_stall;
        logic [7:0] prev_data;

        exp_ready = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset with a request held high: nothing may reach the RAM.
        rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0;
        sample();
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_ram_en", ram_en, 1'b0);
        chk1("rst_ram_wr_en", ram_wr_en, 1'b0);
        next_cycle();
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        sample();
        chk1("post_rst_ready", req_ready, 1'b1);
        chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
        next_cycle();

        // Write 0x5A to 0x10, then read it back on the next cycle.
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h10; req_wdata = 8'h5A;
        sample();
        chk1("wr_ram_en", ram_en, 1'b1);
        chk1("wr_ram_wr_en", ram_wr_en, 1'b1);
        chk8("wr_ram_addr", ram_addr, 8'h10);
        chk8("wr_ram_wr_data", ram_wr_data, 8'h5A);
        next_cycle();
        req_wr = 1'b0;
        sample();
        chk1("rd_ram_wr_en", ram_wr_en, 1'b0);
        chk1("rd_ram_en", ram_en, 1'b1);
        next_cycle();
        req_valid = 1'b0;
        sample();
        chk1("idle_ram_en", ram_en, 1'b0);
        chk1("lat_t1_rsp_valid", rsp_valid, 1'b0);
        next_cycle();
        sample();
        chk1("lat_t2_rsp_valid", rsp_valid, 1'b1);
        chk8("lat_t2_rsp_data", rsp_data, 8'h5A);
        next_cycle();
        sample();
        chk1("lat_t3_rsp_valid", rsp_valid, 1'b0);
        next_cycle();

        // Write issued while a read response is being pushed and popped.
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h10;
        sample();
        chk1("mix_rd_en", ram_en, 1'b1);
        next_cycle();
        req_wr = 1'b1; req_addr = 8'h11; req_wdata = 8'h77;
        sample();
        chk1("mix_wr_en", ram_wr_en, 1'b1);
        chk1("mix_c1_rsp_valid", rsp_valid, 1'b0);
        next_cycle();
        req_wr = 1'b0; req_addr = 8'h11;
        sample();
        chk1("mix_c2_rsp_valid", rsp_valid, 1'b1);
        chk8("mix_c2_rsp_data", rsp_data, 8'h5A);
        chk1("mix_c2_ram_wr_en", ram_wr_en, 1'b0);
        next_cycle();
        req_valid = 1'b0;
        sample();
        chk1("mix_c3_rsp_valid", rsp_valid, 1'b0);
        next_cycle();
        sample();
        chk1("mix_c4_rsp_valid", rsp_valid, 1'b1);
        chk8("mix_c4_rsp_data", rsp_data, 8'h77);
        next_cycle();
        sample();
        chk1("mix_c5_rsp_valid", rsp_valid, 1'b0);
        next_cycle();

        // Eight back-to-back reads with the consumer always ready.
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 8); req_wr = 1'b0; req_addr = 8'(c);
            sample();
            if (c < 8)
                chk1("stream_req_ready", req_ready, 1'b1);
            if (c >= 2 && c < 10) begin
                chk1("stream_rsp_valid", rsp_valid, 1'b1);
                chk8("stream_rsp_data", rsp_data, 8'(8'hA0 + c - 2));
            end else begin
                chk1("stream_rsp_idle", rsp_valid, 1'b0);
            end
            next_cycle();
        end

        // Stalled consumer: exactly three reads accepted, head held stable.
        rsp_ready = 1'b0; na = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'(na);
            sample();
            chk1("stall_req_ready", req_ready, exp_ready[c]);
            if (c >= 2) begin
                chk1("stall_rsp_valid", rsp_valid, 1'b1);
                chk8("stall_rsp_data", rsp_data, 8'hA0);
            end
            if (req_ready)
                na++;
            next_cycle();
        end
        chk1("stall_accepted_3", na == 3, 1'b1);
        // Full FIFO: pop frees a credit, the held read is accepted next cycle.
        req_addr = 8'(na); rsp_ready = 1'b1;
        sample();
        chk1("full_req_ready", req_ready, 1'b0);
        chk8("drain_0", rsp_data, 8'hA0);
        next_cycle();
        sample();
        chk1("credit_back_ready", req_ready, 1'b1);
        chk8("drain_1", rsp_data, 8'hA1);
        next_cycle();
        req_valid = 1'b0;
        sample();
        chk1("drain_2_valid", rsp_valid, 1'b1);
        chk8("drain_2", rsp_data, 8'hA2);
        next_cycle();
        sample();
        chk1("drain_3_valid", rsp_valid, 1'b1);
        chk8("drain_3", rsp_data, 8'hA3);
        next_cycle();
        sample();
        chk1("drain_done", rsp_valid, 1'b0);
        next_cycle();

        // Reset mid-operation with two buffered responses and one pending.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1; req_addr = 8'(c);
            sample();
            next_cycle();
        end
        chk1("pre_rst_rsp_valid", rsp_valid, 1'b1);
        chk1("pre_rst_full", req_ready, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk1("async_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("async_rst_ready", req_ready, 1'b0);
        chk1("async_rst_ram_en", ram_en, 1'b0);
        next_cycle();
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        sample();
        chk1("rel_req_ready", req_ready, 1'b1);
        for (int c = 0; c < 4; c++) begin
            chk1("rel_no_rsp", rsp_valid, 1'b0);
            next_cycle();
            sample();
        end
        next_cycle();

        // Random traffic against a reference memory and expected-data queue.
        for (int i = 0; i < 256; i++)
            ref_mem[i] = ram_mem[i];
        prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 10000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom_range(0, 15));
            req_wdata = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            sample();
            chk1("no_overflow", (dut.count == 2'd3) && dut.pending && !(rsp_valid && rsp_ready), 1'b0);
            if (prev_stall) begin
                chk1("hold_valid", rsp_valid, 1'b1);
                chk8("hold_data", rsp_data, prev_data);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk1("rand_spurious_rsp", 1'b1, 1'b0);
                end else begin
                    chk8("rand_rsp_data", rsp_data, exp_q.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                if (req_wr)
                    ref_mem[req_addr] = req_wdata;
                else
                    exp_q.push_back(ref_mem[req_addr]);
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            next_cycle();
        end

        // Drain what is left, with a bounded number of cycles.
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            sample();
            if (rsp_valid) begin
                if (exp_q.size() == 0)
                    chk1("drain_spurious_rsp", 1'b1, 1'b0);
                else
                    chk8("drain_rsp_data", rsp_data, exp_q.pop_front());
            end
            next_cycle();
        end
        chk1("drain_queue_empty", exp_q.size() == 0, 1'b1);
        sample();
        chk1("drain_rsp_idle", rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spram_ctrl.md
SPRAM_CTRL -- requirements
Module: spram_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DATA_DEPTH, default 256, RAM words; AW = $clog2(DATA_DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle if req_valid also high.
REQ-007 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  AW  word address.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rsp_valid  output  1  read response present.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-012 SHALL have port rsp_data  output  DATA_WIDTH  read data, head of response buffer.
REQ-013 SHALL have port ram_en  output  1  RAM enable.
REQ-014 SHALL have port ram_wr_en  output  1  RAM write enable.
REQ-015 SHALL have port ram_addr  output  AW  RAM address.
REQ-016 SHALL have port ram_wr_data  output  DATA_WIDTH  RAM write data.
REQ-017 SHALL have port ram_rd_data  input  DATA_WIDTH  RAM registered read data, valid the cycle after a read issue, held until the next read.

Function
REQ-018 SHALL form the request handshake as req_fire = req_valid & req_ready; transfers only on req_fire.
REQ-019 SHALL drive ram_en = req_fire, ram_wr_en = req_fire & req_wr, ram_addr = req_addr, ram_wr_data = req_wdata (combinational pass-through, no added latency).
REQ-020 SHALL hold a 1-bit register pending, set on the edge after a read req_fire, cleared otherwise.
REQ-021 SHALL contain a 3-entry response FIFO (count 0..3, wrapping read/write pointers).
REQ-022 SHALL push ram_rd_data into the FIFO on every cycle in which pending = 1.
REQ-023 SHALL drive rsp_valid = (count != 0) and rsp_data = FIFO head; pop on rsp_valid & rsp_ready.
REQ-024 SHALL drive req_ready = (count + pending < 3), registered state only, no combinational path from req_valid, req_wr or rsp_ready.
REQ-025 SHALL apply the same credit rule to writes and reads, so request order is preserved.
REQ-026 SHALL give read latency: read fire at cycle t -> rsp_valid earliest at t+2 with the data of that address.
REQ-027 SHALL sustain one request per cycle and one response per cycle when rsp_ready is held high.
REQ-028 SHALL update count as count + push - pop on simultaneous push and pop, including at count = 3 with pop.
REQ-029 SHALL never overflow: push at count = 3 without pop is unreachable by REQ-024; verification asserts this.
REQ-030 SHALL hold rsp_valid and rsp_data stable while rsp_valid & !rsp_ready.
REQ-031 SHALL return new data for a read in cycle t+1 after a write to the same address in cycle t.
REQ-032 SHALL accept a write in the same cycle a read response is pushed or popped, with no interference.

Reset
REQ-033 SHALL, on rst assertion, immediately and asynchronously clear pending, count and both pointers.
REQ-034 SHALL hold rsp_valid = 0, req_ready = 0, ram_en = 0, ram_wr_en = 0 while rst is high.
REQ-035 SHALL discard in-flight reads and buffered responses on reset mid-operation; no response appears after release.
REQ-036 SHALL assert req_ready = 1 in the first cycle after rst deasserts.
REQ-037 SHALL not reset FIFO data storage; rsp_data is don't-care while rsp_valid = 0.

Verification
REQ-038 SHALL cover write 0x5A to addr 0x10 then read 0x10 back-to-back -> ram_wr_en pulse 1 cycle, rsp_valid at read-fire+2, rsp_data = 0x5A.
REQ-039 SHALL cover 8 consecutive reads of addr 0..7 (preloaded 0xA0..0xA7), rsp_ready = 1 -> req_ready stays 1, 8 responses on consecutive cycles in order.
REQ-040 SHALL cover rsp_ready = 0 while issuing reads -> exactly 3 reads accepted, req_ready = 0 thereafter, no data lost; raise rsp_ready -> 0xA0, 0xA1, 0xA2 in order.
REQ-041 SHALL cover count = 3 with rsp_ready = 1 and req_valid = 1 -> pop that cycle, req_ready returns to 1 next cycle, count never exceeds 3.
REQ-042 SHALL cover rst asserted mid-edge with 2 buffered responses and 1 pending -> rsp_valid drops to 0 asynchronously, no response after release, req_ready = 1 the next cycle.
REQ-043 SHALL cover random req/rsp valid/ready stimulus for 10k cycles against a reference memory model -> all read data match, ordering preserved, no overflow assertion fires.
